// File: rtl/serial_add_ctrl_if.sv
// Handshake/bus bundle for serial_add_ctrl.
// SERIAL_ADD_OVF_EN adds the ovf result signal.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer around one fa_ha, LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
module fa_ha (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    // Upper WIDTH-1 bits of the sum shifter; the bit that would
    // fall out the bottom is only needed on the final edge.
    logic [WIDTH-2:0] r_sum_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             r_ovf;
`endif

    logic             w_fa_sum;
    logic             w_fa_carry;
    logic [WIDTH-1:0] w_sum_cat;
    logic             w_last;

    fa_ha u_fa (
        .i_a     (r_a_sh[0]),
        .i_b     (r_b_sh[0]),
        .i_c     (r_carry),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    assign w_sum_cat = {w_fa_sum, r_sum_sh};
    assign w_last    = (r_cnt == LAST);

    // Sequencer: capture, one bit per edge, one-cycle DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum_sh <= w_sum_cat[WIDTH-1:1];
                    r_carry  <= w_fa_carry;
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum   <= w_sum_cat;
                        r_cout  <= w_fa_carry;
`ifdef SERIAL_ADD_OVF_EN
                        // r_carry here is the carry into the MSB.
                        r_ovf   <= r_carry ^ w_fa_carry;
`endif
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = r_ovf;
`endif
endmodule
